// File: rtl/reg_bank_sb_if.sv
// Bus bundle for reg_bank_sb: two read ports, writeback port, destination-claim port.
// master = issue/writeback side, slave = the register bank.
interface reg_bank_sb_if #(
   parameter int XLEN  = 32,
   parameter int NREGS = 32
);
   localparam int AW = $clog2(NREGS);

   logic [AW-1:0]    rs1_addr;
   logic [AW-1:0]    rs2_addr;
   logic [XLEN-1:0]  rs1_data;
   logic [XLEN-1:0]  rs2_data;
   logic             rs1_busy;
   logic             rs2_busy;
   logic             wr_en;
   logic [AW-1:0]    wr_addr;
   logic [XLEN-1:0]  wr_data;
   logic             claim_en;
   logic [AW-1:0]    claim_addr;
   logic             claim_ok;
   logic [NREGS-1:0] busy_vec;

   modport master (
      output rs1_addr, rs2_addr, wr_en, wr_addr, wr_data, claim_en, claim_addr,
      input  rs1_data, rs2_data, rs1_busy, rs2_busy, claim_ok, busy_vec
   );

   modport slave (
      input  rs1_addr, rs2_addr, wr_en, wr_addr, wr_data, claim_en, claim_addr,
      output rs1_data, rs2_data, rs1_busy, rs2_busy, claim_ok, busy_vec
   );
endinterface

// File: rtl/reg_bank_sb.sv
// Architectural register file with optional write-through bypass and a per-register
// busy scoreboard used by issue to detect RAW hazards and stall on WAW.
module reg_bank_sb #(
   parameter int          XLEN    = 32,
   parameter int          NREGS   = 32,
   parameter logic [31:0] SP_INIT = 32'h7fffeffc,
   parameter logic [31:0] GP_INIT = 32'h10008000,
   parameter bit          BYPASS  = 1'b1
) (
   input  logic         clk,
   input  logic         reset,
   reg_bank_sb_if.slave bus
);
   localparam int AW = $clog2(NREGS);

   logic [XLEN-1:0]  regs_q [NREGS];
   logic [XLEN-1:0]  regs_d [NREGS];
   logic [NREGS-1:0] busy_q;
   logic [NREGS-1:0] busy_d;

   logic             wr_commit;
   logic             claim_ok;
   logic             rs1_fwd;
   logic             rs2_fwd;
   logic [XLEN-1:0]  rs1_data;
   logic [XLEN-1:0]  rs2_data;
   logic             rs1_busy;
   logic             rs2_busy;

   function automatic logic [XLEN-1:0] init_value(input int idx);
      if (idx == 2) return XLEN'(SP_INIT);
      if (idx == 3) return XLEN'(GP_INIT);
      return '0;
   endfunction

   assign wr_commit = bus.wr_en && (bus.wr_addr != '0);

   // A busy destination may still be claimed when its producer retires this cycle.
   assign claim_ok = bus.claim_en &&
                     ((bus.claim_addr == '0) ||
                      !busy_q[bus.claim_addr] ||
                      (bus.wr_en && (bus.wr_addr == bus.claim_addr)));

   always_comb begin
      for (int i = 0; i < NREGS; i++) begin
         regs_d[i] = regs_q[i];
         if (wr_commit && (bus.wr_addr == AW'(i))) begin
            regs_d[i] = bus.wr_data;
         end
      end
   end

   // Claim is applied after the write's clear so it wins on a shared destination.
   always_comb begin
      busy_d = busy_q;
      if (wr_commit) begin
         busy_d[bus.wr_addr] = 1'b0;
      end
      if (claim_ok && (bus.claim_addr != '0)) begin
         busy_d[bus.claim_addr] = 1'b1;
      end
      busy_d[0] = 1'b0;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NREGS; i++) begin
            regs_q[i] <= init_value(i);
         end
         busy_q <= '0;
      end else begin
         regs_q <= regs_d;
         busy_q <= busy_d;
      end
   end

   assign rs1_fwd = BYPASS && bus.wr_en && (bus.wr_addr == bus.rs1_addr);
   assign rs2_fwd = BYPASS && bus.wr_en && (bus.wr_addr == bus.rs2_addr);

   always_comb begin
      rs1_data = regs_q[bus.rs1_addr];
      rs1_busy = busy_q[bus.rs1_addr];
      if (bus.rs1_addr == '0) begin
         rs1_data = '0;
         rs1_busy = 1'b0;
      end else if (rs1_fwd) begin
         rs1_data = bus.wr_data;
         rs1_busy = 1'b0;
      end
   end

   always_comb begin
      rs2_data = regs_q[bus.rs2_addr];
      rs2_busy = busy_q[bus.rs2_addr];
      if (bus.rs2_addr == '0) begin
         rs2_data = '0;
         rs2_busy = 1'b0;
      end else if (rs2_fwd) begin
         rs2_data = bus.wr_data;
         rs2_busy = 1'b0;
      end
   end

   assign bus.rs1_data = rs1_data;
   assign bus.rs2_data = rs2_data;
   assign bus.rs1_busy = rs1_busy;
   assign bus.rs2_busy = rs2_busy;
   assign bus.claim_ok = claim_ok;
   assign bus.busy_vec = busy_q;
endmodule

// File: tb/tb_reg_bank_sb.sv
// Directed scoreboard bench: one bypassing (a) and one non-bypassing (b) bank share stimulus;
// expectations are queued by the stimulus and drained by an independent monitor.
module tb_reg_bank_sb;
   logic clk;
   logic reset;

   reg_bank_sb_if #(.XLEN(32), .NREGS(32)) ia ();
   reg_bank_sb_if #(.XLEN(32), .NREGS(32)) ib ();

   reg_bank_sb #(.XLEN(32), .NREGS(32), .BYPASS(1'b1)) dut_a (.clk(clk), .reset(reset), .bus(ia));
   reg_bank_sb #(.XLEN(32), .NREGS(32), .BYPASS(1'b0)) dut_b (.clk(clk), .reset(reset), .bus(ib));

   typedef struct {
      int          id;
      logic [31:0] exp;
   } exp_t;

   exp_t sb_q[$];
   int   errors = 0;
   int   checks = 0;
   event sample_ev;

   localparam int RS1D = 0, RS2D = 1, RS1B = 2, RS2B = 3, COK = 4, BVEC = 5, B = 8;

   initial clk = 1'b0;
   always #10 clk = ~clk;

   function automatic logic [31:0] obs(input int id);
      case (id)
         RS1D:     return ia.rs1_data;
         RS2D:     return ia.rs2_data;
         RS1B:     return {31'b0, ia.rs1_busy};
         RS2B:     return {31'b0, ia.rs2_busy};
         COK:      return {31'b0, ia.claim_ok};
         BVEC:     return ia.busy_vec;
         B + RS1D: return ib.rs1_data;
         B + RS2D: return ib.rs2_data;
         B + RS1B: return {31'b0, ib.rs1_busy};
         B + RS2B: return {31'b0, ib.rs2_busy};
         B + COK:  return {31'b0, ib.claim_ok};
         B + BVEC: return ib.busy_vec;
         default:  return 32'hxxxx_xxxx;
      endcase
   endfunction

   function automatic string name_of(input int id);
      string inst;
      string fld;
      inst = (id >= B) ? "b" : "a";
      case (id % B)
         RS1D:    fld = "rs1_data";
         RS2D:    fld = "rs2_data";
         RS1B:    fld = "rs1_busy";
         RS2B:    fld = "rs2_busy";
         COK:     fld = "claim_ok";
         BVEC:    fld = "busy_vec";
         default: fld = "unknown";
      endcase
      return {inst, ".", fld};
   endfunction

   task automatic push(input int id, input logic [31:0] v);
      exp_t e;
      e.id  = id;
      e.exp = v;
      sb_q.push_back(e);
   endtask

   task automatic push2(input int id, input logic [31:0] v);
      push(id, v);
      push(id + B, v);
   endtask

   task automatic drive(input logic [4:0] r1, input logic [4:0] r2,
                        input logic we, input logic [4:0] wa, input logic [31:0] wd,
                        input logic ce, input logic [4:0] ca);
      ia.rs1_addr = r1;  ib.rs1_addr = r1;
      ia.rs2_addr = r2;  ib.rs2_addr = r2;
      ia.wr_en    = we;  ib.wr_en    = we;
      ia.wr_addr  = wa;  ib.wr_addr  = wa;
      ia.wr_data  = wd;  ib.wr_data  = wd;
      ia.claim_en = ce;  ib.claim_en = ce;
      ia.claim_addr = ca; ib.claim_addr = ca;
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   // Monitor: outputs are combinational, so each negedge (or an explicit sample request)
   // is a point where the bank presents a stable response.
   initial begin
      exp_t        e;
      logic [31:0] act;
      forever begin
         @(negedge clk or sample_ev);
         #1;
         while (sb_q.size() > 0) begin
            e   = sb_q.pop_front();
            act = obs(e.id);
            checks++;
            if (act !== e.exp) begin
               errors++;
               $display("FAIL %s: got %h expected %h", name_of(e.id), act, e.exp);
            end else begin
               $display("check %s = %h ok", name_of(e.id), act);
            end
         end
      end
   end

   initial begin
      reset = 1'b1;
      drive(5'd0, 5'd2, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
      next_cycle();
      push2(BVEC, 32'h0);
      push2(RS2D, 32'h7fffeffc);

      // reset release: init values
      next_cycle();
      reset = 1'b0;
      drive(5'd0, 5'd2, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
      push2(RS1D, 32'h0);
      push2(RS2D, 32'h7fffeffc);
      push2(BVEC, 32'h0);

      next_cycle();
      drive(5'd3, 5'd5, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
      push2(RS1D, 32'h10008000);
      push2(RS2D, 32'h0);

      // write x5 with same-cycle read
      next_cycle();
      drive(5'd5, 5'd0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0);
      push(RS1D, 32'hDEADBEEF);
      push(RS1B, 32'h0);
      push(B + RS1D, 32'h0);

      next_cycle();
      drive(5'd5, 5'd0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
      push2(RS1D, 32'hDEADBEEF);

      // claim x7
      next_cycle();
      drive(5'd0, 5'd7, 1'b0, 5'd0, 32'h0, 1'b1, 5'd7);
      push2(COK, 32'h1);
      push2(RS2B, 32'h0);

      // re-claim x7 while busy: WAW stall
      next_cycle();
      drive(5'd0, 5'd7, 1'b0, 5'd0, 32'h0, 1'b1, 5'd7);
      push2(RS2B, 32'h1);
      push2(BVEC, 32'h0000_0080);
      push2(COK, 32'h0);

      // writeback x7 with same-cycle re-claim
      next_cycle();
      drive(5'd0, 5'd7, 1'b1, 5'd7, 32'h12, 1'b1, 5'd7);
      push2(COK, 32'h1);
      push(RS2B, 32'h0);
      push(RS2D, 32'h12);
      push(B + RS2B, 32'h1);
      push(B + RS2D, 32'h0);

      next_cycle();
      drive(5'd0, 5'd7, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
      push2(RS2B, 32'h1);
      push2(RS2D, 32'h12);
      push2(BVEC, 32'h0000_0080);

      // x0 write and claim are ignored but the claim is accepted
      next_cycle();
      drive(5'd0, 5'd0, 1'b1, 5'd0, 32'hFFFF_FFFF, 1'b1, 5'd0);
      push2(RS1D, 32'h0);
      push2(COK, 32'h1);

      // claim x9 and write x4 together
      next_cycle();
      drive(5'd4, 5'd9, 1'b1, 5'd4, 32'hA5A5_0004, 1'b1, 5'd9);
      push(RS1D, 32'hA5A5_0004);
      push(B + RS1D, 32'h0);
      push2(RS2B, 32'h0);
      push2(COK, 32'h1);
      push2(BVEC, 32'h0000_0080);

      next_cycle();
      drive(5'd4, 5'd9, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
      push2(RS1D, 32'hA5A5_0004);
      push2(RS1B, 32'h0);
      push2(RS2B, 32'h1);
      push2(BVEC, 32'h0000_0280);

      // overwrite x2, claim x3
      next_cycle();
      drive(5'd2, 5'd0, 1'b1, 5'd2, 32'h0000_1111, 1'b1, 5'd3);
      push(RS1D, 32'h0000_1111);
      push(B + RS1D, 32'h7fffeffc);
      push2(COK, 32'h1);

      // busy state set, pending write/claim, then asynchronous reset mid-cycle
      next_cycle();
      drive(5'd2, 5'd3, 1'b1, 5'd5, 32'h0000_0055, 1'b1, 5'd6);
      push2(RS1D, 32'h0000_1111);
      push2(RS2D, 32'h10008000);
      push2(RS2B, 32'h1);
      push2(BVEC, 32'h0000_0288);
      @(negedge clk);
      #3;
      reset = 1'b1;
      #1;
      push2(BVEC, 32'h0);
      push2(RS1D, 32'h7fffeffc);
      push2(RS2D, 32'h10008000);
      push2(RS2B, 32'h0);
      ->sample_ev;

      next_cycle();
      reset = 1'b0;
      drive(5'd5, 5'd6, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
      push2(RS1D, 32'h0);
      push2(RS2B, 32'h0);
      push2(BVEC, 32'h0);

      begin
         int budget;
         budget = 0;
         @(negedge clk);
         #2;
         while (sb_q.size() > 0 && budget < 10) begin
            @(negedge clk);
            #2;
            budget++;
         end
         if (sb_q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: got %0d pending expected 0", sb_q.size());
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/reg_bank_sb.md
# reg_bank_sb

Parametrised register bank with write-through bypass and a per-register busy scoreboard. It is the next-generation architectural register file for the pipelined core: two combinational read ports, one writeback port, and one destination-claim port. The claim port lets issue logic mark a destination as pending and detect RAW/WAW hazards without external bookkeeping. It sits between decode/issue (read, claim) and writeback (write).

## Interface
- XLEN, 32: data width in bits.
- NREGS, 32: number of registers, power of two, ≥4; AW = $clog2(NREGS).
- SP_INIT, 32'h7fffeffc: reset value of register 2 (truncated/zero-extended to XLEN).
- GP_INIT, 32'h10008000: reset value of register 3.
- BYPASS, 1: 1 = same-cycle write is forwarded to read ports; 0 = reads return the stored value.

- clk  in  1  clock, all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- rs1_addr  in  AW  read port 1 address.
- rs2_addr  in  AW  read port 2 address.
- rs1_data  out  XLEN  read port 1 data.
- rs2_data  out  XLEN  read port 2 data.
- rs1_busy  out  1  read port 1 register has an outstanding producer.
- rs2_busy  out  1  read port 2 register has an outstanding producer.
- wr_en  in  1  writeback strobe.
- wr_addr  in  AW  writeback destination.
- wr_data  in  XLEN  writeback data.
- claim_en  in  1  issue requests ownership of claim_addr.
- claim_addr  in  AW  destination being claimed.
- claim_ok  out  1  claim accepted this cycle.
- busy_vec  out  NREGS  scoreboard state, bit i = register i pending.

## Operation
- Storage: NREGS × XLEN array plus NREGS busy bits. Register 0 always reads 0, is never busy, and ignores writes and claims.
- Reset, asserted asynchronously: all registers 0 except reg 2 = SP_INIT and reg 3 = GP_INIT. All busy bits 0. claim_ok is combinational and reads 0 unless claim_en. Outputs follow the reset contents immediately.
- Write: on a rising edge with wr_en=1 and wr_addr≠0, the array is updated and busy[wr_addr] is cleared. Writing a non-busy register is legal: data is updated and busy stays 0.
- Read, combinational: rsN_data = 0 if rsN_addr=0.
  - Otherwise, with BYPASS=1 and wr_en=1 and wr_addr=rsN_addr, rsN_data = wr_data.
  - Otherwise rsN_data = the array value.
- rsN_busy = busy[rsN_addr], forced 0 if rsN_addr=0. With BYPASS=1 it is also forced 0 when the same-cycle write targets rsN_addr.
- claim_ok = claim_en and any one of:
  - claim_addr = 0, or
  - busy[claim_addr] = 0, or
  - wr_en=1 and wr_addr=claim_addr (the producer retires this cycle).
- A busy register with no matching write rejects the claim; this is the WAW stall.
- Claim: on a rising edge with claim_ok=1 and claim_addr≠0, busy[claim_addr] is set.
- Simultaneous write and claim to the same register: data is written and busy ends at 1, because the claim wins over the write's clear.
- Write and claim to different registers update independently.
- busy_vec is the registered busy bits, bit 0 always 0.

## Timing
- Read latency is 0 cycles (combinational from address and bypass inputs). Write data is visible from the array one edge later, or in the same cycle via bypass.
- Claim takes effect at the next edge. rsN_busy reflects a claim made in cycle t from cycle t+1.
- Writeback clears busy at the edge. With BYPASS=1, consumers see busy=0 and the forwarded data during the write cycle itself.
- Reset mid-operation: pending writes and claims in that cycle are discarded. State returns to init values asynchronously and remains there while reset is high.
- No handshake back-pressure on writeback; wr_en is always accepted.

## Test plan
- Reset, then read addresses 0, 2, 3, 5 -> 0, 32'h7fffeffc, 32'h10008000, 0; busy_vec = 0.
- Write x5=32'hDEADBEEF and read rs1=5 in the same cycle:
  - BYPASS=1 -> rs1_data = DEADBEEF, rs1_busy=0.
  - BYPASS=0 -> rs1_data = 0; reads DEADBEEF next cycle.
- Claim x7, then read rs2=7 next cycle -> rs2_busy=1, busy_vec[7]=1.
  - Re-claim x7 -> claim_ok=0.
  - Write x7=32'h12 -> busy clears; the same-cycle re-claim gets claim_ok=1 and busy stays 1.
- Write x0=32'hFFFF_FFFF and claim x0 -> rs1_data(0)=0, claim_ok=1, busy_vec[0]=0.
- Claim x9 and write x4 in the same cycle -> x4 updated, busy[9]=1, busy[4]=0.
- Assert reset asynchronously, mid-cycle, with busy bits set and wr_en active -> busy_vec=0 immediately and x2/x3 restored; the write is lost.
